// File: rtl/shift_pipe.sv
// Pipelined SHL/SHR/SRA shifter with valid/ready handshakes, sideband tag and flush.
// Define SHIFT_ROTATE_EN to make sfn=2'b10 a rotate-left; otherwise it returns 0.
module shift_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 5,
  localparam int unsigned SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sfn,
  input  logic [WIDTH-1:0] in_a,
  input  logic [SW-1:0]    in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [1:0] SfnShl = 2'b00;
  localparam logic [1:0] SfnShr = 2'b01;
  localparam logic [1:0] SfnSra = 2'b11;

  logic [STAGES-1:0] r_valid;
  logic [WIDTH-1:0]  r_data [STAGES];
  logic [1:0]        r_sfn  [STAGES];
  logic [SW-1:0]     r_amt  [STAGES];
  logic              r_sign [STAGES];
  logic [TAG_W-1:0]  r_tag  [STAGES];

  logic [STAGES-1:0] w_adv;
  logic [STAGES-1:0] w_load;
  logic [WIDTH-1:0]  w_din  [STAGES];
  logic [1:0]        w_sfn  [STAGES];
  logic [SW-1:0]     w_amt  [STAGES];
  logic              w_sign [STAGES];
  logic [TAG_W-1:0]  w_tag  [STAGES];
  logic [WIDTH-1:0]  w_res  [STAGES];

  // One log-shifter step by a power-of-two amount.
  function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] d,
                                              input logic [1:0]       sfn,
                                              input logic             sign,
                                              input int               sh);
    logic [WIDTH-1:0] r;
    unique case (sfn)
      SfnShl:  r = d << sh;
      SfnShr:  r = d >> sh;
      SfnSra:  r = (d >> sh) | ({WIDTH{sign}} & ~({WIDTH{1'b1}} >> sh));
`ifdef SHIFT_ROTATE_EN
      default: r = (d << sh) | (d >> (WIDTH - sh));
`else
      default: r = '0;
`endif
    endcase
    return r;
  endfunction

  // Applies amount bits [lo..hi] to the stage input.
  function automatic logic [WIDTH-1:0] f_stage(input logic [WIDTH-1:0] d,
                                               input logic [1:0]       sfn,
                                               input logic [SW-1:0]    amt,
                                               input logic             sign,
                                               input int               lo,
                                               input int               hi);
    logic [WIDTH-1:0] r;
    r = d;
    for (int j = 0; j < SW; j++) begin
      if (j >= lo && j <= hi && amt[j]) begin
        r = f_step(r, sfn, sign, 1 << j);
      end
    end
`ifndef SHIFT_ROTATE_EN
    if (sfn == 2'b10) begin
      r = '0;
    end
`endif
    return r;
  endfunction

  assign w_din[0]  = in_a;
  assign w_sfn[0]  = in_sfn;
  assign w_amt[0]  = in_b;
  assign w_sign[0] = in_a[WIDTH-1];
  assign w_tag[0]  = in_tag;

  for (genvar g = 1; g < STAGES; g++) begin : g_link
    assign w_din[g]  = r_data[g-1];
    assign w_sfn[g]  = r_sfn[g-1];
    assign w_amt[g]  = r_amt[g-1];
    assign w_sign[g] = r_sign[g-1];
    assign w_tag[g]  = r_tag[g-1];
  end

  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      w_res[i] = f_stage(w_din[i], w_sfn[i], w_amt[i], w_sign[i],
                         (i * SW) / STAGES, ((i + 1) * SW) / STAGES - 1);
    end
  end

  // A stage advances if any downstream slot is empty or the consumer takes the result;
  // written without a self-referencing chain so the comb graph stays acyclic.
  always_comb begin
    w_adv = '0;
    for (int i = 0; i < STAGES; i++) begin
      logic w_room;
      w_room = out_ready;
      for (int k = i + 1; k < STAGES; k++) begin
        if (!r_valid[k]) begin
          w_room = 1'b1;
        end
      end
      w_adv[i] = r_valid[i] && w_room;
    end
  end

  assign in_ready = !flush && (!r_valid[0] || w_adv[0]);

  always_comb begin
    w_load    = '0;
    w_load[0] = in_valid && in_ready;
    for (int i = 1; i < STAGES; i++) begin
      w_load[i] = w_adv[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_data[i] <= '0;
        r_sfn[i]  <= '0;
        r_amt[i]  <= '0;
        r_sign[i] <= 1'b0;
        r_tag[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (flush) begin
          r_valid[i] <= 1'b0;
        end else if (w_load[i]) begin
          r_valid[i] <= 1'b1;
        end else if (w_adv[i]) begin
          r_valid[i] <= 1'b0;
        end
        if (w_load[i]) begin
          r_data[i] <= w_res[i];
          r_sfn[i]  <= w_sfn[i];
          r_amt[i]  <= w_amt[i];
          r_sign[i] <= w_sign[i];
          r_tag[i]  <= w_tag[i];
        end
      end
    end
  end

  assign out_valid = r_valid[STAGES-1];
  assign out_y     = r_data[STAGES-1];
  assign out_tag   = r_tag[STAGES-1];

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe (WIDTH=32, STAGES=2) against a plain-arithmetic model.
module tb_shift_pipe;

  localparam int WIDTH  = 32;
  localparam int STAGES = 2;
  localparam int TAG_W  = 5;
  localparam int SW     = 5;
`ifdef SHIFT_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_sfn;
  logic [WIDTH-1:0] in_a;
  logic [SW-1:0]    in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic [TAG_W-1:0] out_tag;

  int n_checks = 0;
  int n_errors = 0;
  bit last_acc;

  logic [WIDTH-1:0] exp_y[$];
  logic [TAG_W-1:0] exp_tag[$];
  logic [WIDTH-1:0] obs_y[$];
  logic [TAG_W-1:0] obs_tag[$];

  shift_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sfn   (in_sfn),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .out_tag  (out_tag)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] ref_shift(input logic [1:0] sfn, input logic [WIDTH-1:0] a,
                                                 input logic [SW-1:0] b);
    logic signed [WIDTH-1:0] sa;
    int                      n;
    sa = a;
    n  = int'(b);
    case (sfn)
      2'b00:   return a << n;
      2'b01:   return a >> n;
      2'b11:   return $unsigned(sa >>> n);
      default: begin
        if (!ROT) return '0;
        if (n == 0) return a;
        return (a << n) | (a >> (WIDTH - n));
      end
    endcase
  endfunction

  // Samples both handshakes just after the negedge, then advances one cycle.
  task automatic tick();
    #1;
    last_acc = in_valid && in_ready;
    if (last_acc) begin
      exp_y.push_back(ref_shift(in_sfn, in_a, in_b));
      exp_tag.push_back(in_tag);
    end
    if (out_valid && out_ready) begin
      obs_y.push_back(out_y);
      obs_tag.push_back(out_tag);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] sfn, input logic [WIDTH-1:0] a, input logic [SW-1:0] b,
                       input logic [TAG_W-1:0] tag);
    in_valid = 1'b1;
    in_sfn   = sfn;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (obs_y.size() >= exp_y.size() && !out_valid) break;
      tick();
    end
  endtask

  task automatic clear_queues();
    exp_y.delete();
    exp_tag.delete();
    obs_y.delete();
    obs_tag.delete();
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset out_valid: got %b required 0", out_valid);
    end
    n_checks++;
    if (out_y !== '0) begin
      n_errors++; $display("FAIL reset out_y: got %h required 0", out_y);
    end
    n_checks++;
    if (out_tag !== '0) begin
      n_errors++; $display("FAIL reset out_tag: got %h required 0", out_tag);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    drive(2'b00, 32'h0000_0001, 5'd31, 5'd7);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (last_acc !== 1'b1) begin
      n_errors++; $display("FAIL latency accept: got %b required 1", last_acc);
    end
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++; $display("FAIL latency early valid: got %b required 0", out_valid);
    end
    tick();
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_y !== 32'h8000_0000 || out_tag !== 5'd7) begin
      n_errors++;
      $display("FAIL latency result: got v=%b y=%h t=%0d required v=1 y=80000000 t=7",
               out_valid, out_y, out_tag);
    end
    drain();
    n_checks++;
    if (obs_y.size() != exp_y.size()) begin
      n_errors++; $display("FAIL latency count: got %0d required %0d", obs_y.size(), exp_y.size());
    end
    clear_queues();
  endtask

  task automatic test_sra_srl();
    out_ready = 1'b1;
    drive(2'b11, 32'h8000_0000, 5'd4, 5'd1);
    tick();
    drive(2'b01, 32'h8000_0000, 5'd4, 5'd2);
    tick();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_y !== 32'hF800_0000 || out_tag !== 5'd1) begin
      n_errors++;
      $display("FAIL sra result: got v=%b y=%h t=%0d required v=1 y=f8000000 t=1",
               out_valid, out_y, out_tag);
    end
    tick();
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_y !== 32'h0800_0000 || out_tag !== 5'd2) begin
      n_errors++;
      $display("FAIL srl back-to-back: got v=%b y=%h t=%0d required v=1 y=08000000 t=2",
               out_valid, out_y, out_tag);
    end
    drain();
    clear_queues();
  endtask

  task automatic test_backpressure();
    logic [1:0]       sfn [4];
    logic [WIDTH-1:0] a   [4];
    logic [SW-1:0]    b   [4];
    logic [WIDTH-1:0] hold_y;
    int               k;
    for (int i = 0; i < 4; i++) begin
      sfn[i] = 2'($urandom_range(0, 3));
      a[i]   = $urandom;
      b[i]   = 5'($urandom_range(0, 31));
    end
    hold_y    = ref_shift(sfn[0], a[0], b[0]);
    out_ready = 1'b0;
    drive(sfn[0], a[0], b[0], 5'd1);
    tick();
    drive(sfn[1], a[1], b[1], 5'd2);
    tick();
    k = 2;
    drive(sfn[2], a[2], b[2], 5'd3);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_y !== hold_y || out_tag !== 5'd1) begin
        n_errors++;
        $display("FAIL backpressure hold c%0d: got v=%b y=%h t=%0d required v=1 y=%h t=1",
                 c, out_valid, out_y, out_tag, hold_y);
      end
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_errors++; $display("FAIL backpressure in_ready c%0d: got %b required 0", c, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 20 && k < 4; i++) begin
      drive(sfn[k], a[k], b[k], 5'(k + 1));
      tick();
      if (last_acc) k++;
    end
    n_checks++;
    if (k != 4) begin
      n_errors++; $display("FAIL backpressure accepts: got %0d required 4", k);
    end
    drain();
    n_checks++;
    if (obs_y.size() != 4) begin
      n_errors++; $display("FAIL backpressure count: got %0d required 4", obs_y.size());
    end
    foreach (exp_y[i]) begin
      if (i < obs_y.size()) begin
        n_checks++;
        if (obs_tag[i] !== 5'(i + 1) || obs_y[i] !== exp_y[i]) begin
          n_errors++;
          $display("FAIL backpressure order %0d: got y=%h t=%0d required y=%h t=%0d",
                   i, obs_y[i], obs_tag[i], exp_y[i], i + 1);
        end
      end
    end
    clear_queues();
  endtask

  task automatic test_mode10();
    logic [WIDTH-1:0] want;
    bit               seen;
    want      = ROT ? 32'h0000_0003 : 32'h0000_0000;
    seen      = 1'b0;
    out_ready = 1'b1;
    drive(2'b10, 32'h8000_0001, 5'd1, 5'd9);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      @(negedge clk);
    end
    n_checks++;
    if (!seen) begin
      n_errors++; $display("FAIL mode10 timeout: got no out_valid required out_valid within 10");
    end else begin
      n_checks++;
      if (out_y !== want || out_tag !== 5'd9) begin
        n_errors++;
        $display("FAIL mode10 result: got y=%h t=%0d required y=%h t=9", out_y, out_tag, want);
      end
    end
    drain();
    clear_queues();
  endtask

  task automatic test_flush();
    int n_seen;
    out_ready = 1'b1;
    drive(2'b00, $urandom, 5'd3, 5'd1);
    tick();
    drive(2'b01, $urandom, 5'd5, 5'd2);
    tick();
    drive(2'b11, $urandom, 5'd7, 5'd3);
    flush = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_errors++; $display("FAIL flush in_ready: got %b required 0", in_ready);
    end
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++; $display("FAIL flush out_valid: got %b required 0", out_valid);
    end
    n_seen = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (out_valid) n_seen++;
      @(posedge clk);
      @(negedge clk);
    end
    n_checks++;
    if (n_seen != 0) begin
      n_errors++; $display("FAIL flush leftovers: got %0d valid cycles required 0", n_seen);
    end
    clear_queues();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    drive(2'b00, 32'h1234_5678, 5'd1, 5'd5);
    tick();
    drive(2'b01, 32'h8765_4321, 5'd2, 5'd6);
    tick();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_errors++; $display("FAIL areset precondition: got %b required 1", out_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_y !== '0 || out_tag !== '0) begin
      n_errors++;
      $display("FAIL areset outputs: got v=%b y=%h t=%0d required v=0 y=0 t=0",
               out_valid, out_y, out_tag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_queues();
  endtask

  task automatic test_zero_shift();
    logic [WIDTH-1:0] want;
    out_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      drive(2'(s), 32'hDEAD_BEEF, 5'd0, 5'(s));
      tick();
    end
    drain();
    n_checks++;
    if (obs_y.size() != 4) begin
      n_errors++; $display("FAIL zero-shift count: got %0d required 4", obs_y.size());
    end
    foreach (obs_y[i]) begin
      want = (obs_tag[i] == 5'd2 && !ROT) ? 32'h0 : 32'hDEAD_BEEF;
      n_checks++;
      if (obs_y[i] !== want || obs_tag[i] !== 5'(i)) begin
        n_errors++;
        $display("FAIL zero-shift %0d: got y=%h t=%0d required y=%h t=%0d",
                 i, obs_y[i], obs_tag[i], want, i);
      end
    end
    clear_queues();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sfn    = 2'($urandom_range(0, 3));
      in_a      = $urandom;
      in_b      = 5'($urandom_range(0, 31));
      in_tag    = 5'($urandom_range(0, 31));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
    n_checks++;
    if (obs_y.size() != exp_y.size()) begin
      n_errors++; $display("FAIL random count: got %0d required %0d", obs_y.size(), exp_y.size());
    end
    foreach (exp_y[i]) begin
      if (i < obs_y.size()) begin
        n_checks++;
        if (obs_y[i] !== exp_y[i] || obs_tag[i] !== exp_tag[i]) begin
          n_errors++;
          $display("FAIL random op %0d: got y=%h t=%0d required y=%h t=%0d",
                   i, obs_y[i], obs_tag[i], exp_y[i], exp_tag[i]);
        end
      end
    end
    clear_queues();
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_sfn    = '0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    @(negedge clk);
    test_latency();
    test_sra_srl();
    test_backpressure();
    test_mode10();
    test_flush();
    test_async_reset();
    test_zero_shift();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
